// File: rtl/rgb_pwm_pkg.sv
// Shared constants, parser state type and baud helper for the UART-driven PWM LED block.
package rgb_pwm_pkg;

    localparam int         HDR_FLAG = 7;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic {
        HDR,
        DUTY
    } parser_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // An acknowledge echoes the header byte, which is the flag bit plus the channel number.
    function automatic logic [7:0] ack_byte(input logic [6:0] ch);
        return {1'b1, ch};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: two-flop synchronizer, mid-start glitch rejection, centre sampling, stop-bit check.
module uart_rx_byte
    import rgb_pwm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       pll_clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic          meta_q, sync_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (prev_q && !sync_q) state_d = RX_START;
            RX_START: if (cnt_q == HALF_M1) state_d = sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_q == FULL_M1 && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (cnt_q == FULL_M1) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            RX_START: if (cnt_q == HALF_M1) cnt_d = '0;
            RX_DATA: if (cnt_q == FULL_M1) begin
                cnt_d   = '0;
                bit_d   = bit_q + 1'b1;
                shift_d = {sync_q, shift_q[7:1]};
            end
            RX_STOP: if (cnt_q == FULL_M1) begin
                cnt_d = '0;
                // A low stop bit is a framing error; the byte is silently dropped.
                if (sync_q) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rgb_pwm_uart.sv
// Two-byte UART command parser writing per-channel PWM shadow registers, with ACK/NAK reply.
module rgb_pwm_uart
    import rgb_pwm_pkg::*;
#(
    parameter int CLK_HZ         = 12_000_000,
    parameter int BAUD           = 115_200,
    parameter int NUM_CH         = 3,
    parameter int PWM_BITS       = 8,
    parameter int LED_ACTIVE_LOW = 1,
    parameter int TIMEOUT_BITS   = 32
) (
    input  logic              pll_clk,
    input  logic              rst_n,
    input  logic              uart_rx_i,
    output logic              uart_tx_o,
    output logic [NUM_CH-1:0] led_o
);

    localparam int CPB         = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW          = $clog2(CPB);
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * CPB;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic OFF_LVL   = 1'(LED_ACTIVE_LOW);

    logic [7:0] rx_data;
    logic       rx_valid;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .pll_clk (pll_clk),
        .rst_n   (rst_n),
        .rx_i    (uart_rx_i),
        .data_o  (rx_data),
        .valid_o (rx_valid)
    );

    parser_state_e pstate_q, pstate_d;
    logic [6:0]    ch_q;
    logic [TW-1:0] timeout_q;
    logic          hdr_latch, duty_rx, ch_ok, wr_en;
    logic [7:0]    reply_byte;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) pstate_q <= HDR;
        else        pstate_q <= pstate_d;
    end

    always_comb begin
        pstate_d = pstate_q;
        case (pstate_q)
            HDR:  if (rx_valid && rx_data[HDR_FLAG]) pstate_d = DUTY;
            DUTY: if (rx_valid || timeout_q == TW'(TIMEOUT_CYC - 1)) pstate_d = HDR;
            default: pstate_d = HDR;
        endcase
    end

    always_comb begin
        hdr_latch  = (pstate_q == HDR) && rx_valid && rx_data[HDR_FLAG];
        duty_rx    = (pstate_q == DUTY) && rx_valid;
        ch_ok      = ch_q < 7'(NUM_CH);
        wr_en      = duty_rx && ch_ok;
        reply_byte = ch_ok ? ack_byte(ch_q) : NAK_BYTE;
    end

    logic       tx_req_q;
    logic [7:0] tx_byte_q;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= '0;
            timeout_q <= '0;
            tx_req_q  <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            if (hdr_latch) ch_q <= rx_data[6:0];
            if (hdr_latch)              timeout_q <= '0;
            else if (pstate_q == DUTY)  timeout_q <= timeout_q + 1'b1;
            tx_req_q <= duty_rx;
            if (duty_rx) tx_byte_q <= reply_byte;
        end
    end

    logic          tx_q, tx_busy_q;
    logic [8:0]    tx_shift_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;

    // Bit index 0 is the start bit, 1..8 data, 9 the stop bit; requests while busy are dropped.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (!tx_busy_q) begin
            if (tx_req_q) begin
                tx_busy_q  <= 1'b1;
                tx_shift_q <= {1'b1, tx_byte_q};
                tx_q       <= 1'b0;
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
            end
        end else if (tx_cnt_q == CW'(CPB - 1)) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                tx_bit_q   <= tx_bit_q + 1'b1;
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end
    end

    assign uart_tx_o = tx_q;

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] shadow_q [NUM_CH];
    logic [PWM_BITS-1:0] active_q [NUM_CH];
    logic [NUM_CH-1:0]   wr_hit, lit, led_q;
    logic [PWM_BITS-1:0] duty_val;
    logic                wrap;

    assign duty_val = rx_data[7 -: PWM_BITS];
    assign wrap     = (cnt_q == '1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_hit[gi] = wr_en && (ch_q == 7'(gi));
            assign lit[gi]    = cnt_q < active_q[gi];
        end
    endgenerate

    // Active copies load together at the wrap so a period never mixes old and new duties.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            led_q <= {NUM_CH{OFF_LVL}};
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
            led_q <= lit ^ {NUM_CH{OFF_LVL}};
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) shadow_q[i] <= duty_val;
                if (wrap)      active_q[i] <= shadow_q[i];
            end
        end
    end

    assign led_o = led_q;

endmodule

// File: tb/tb_rgb_pwm_uart.sv
// Directed bench for rgb_pwm_uart at 12 clocks per bit, three channels, 8-bit PWM, active-low LEDs.
module tb_rgb_pwm_uart;

    localparam int CPB = 12;

    logic       pll_clk = 1'b0;
    logic       rst_n;
    logic       uart_rx_i;
    logic       uart_tx_o;
    logic [2:0] led_o;

    int n_checks = 0;
    int n_errors = 0;
    int tx_stop_bad = 0;
    logic [7:0] tx_q [$];

    rgb_pwm_uart #(
        .CLK_HZ(12_000_000),
        .BAUD(1_000_000),
        .NUM_CH(3),
        .PWM_BITS(8),
        .LED_ACTIVE_LOW(1),
        .TIMEOUT_BITS(32)
    ) dut (
        .pll_clk   (pll_clk),
        .rst_n     (rst_n),
        .uart_rx_i (uart_rx_i),
        .uart_tx_o (uart_tx_o),
        .led_o     (led_o)
    );

    always #5 pll_clk = ~pll_clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge pll_clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge pll_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(negedge pll_clk);
        end
        uart_rx_i = stop_bit;
        repeat (CPB) @(negedge pll_clk);
        uart_rx_i = 1'b1;
        $display("rx sent 0x%02h stop=%0d", b, stop_bit);
    endtask

    task automatic expect_reply(input string tag, input logic [7:0] exp);
        int n = 0;
        while (tx_q.size() == 0 && n < 600) begin
            @(negedge pll_clk);
            n++;
        end
        check_val({tag, "_present"}, (tx_q.size() != 0) ? 1 : 0, 1);
        if (tx_q.size() != 0) check_val(tag, int'(tx_q.pop_front()), int'(exp));
    endtask

    // Any 256-cycle window of a periodic 256-cycle PWM contains exactly 'duty' lit cycles.
    task automatic measure(input string tag, input int e0, input int e1, input int e2);
        int lows [3];
        for (int c = 0; c < 3; c++) lows[c] = 0;
        repeat (300) @(negedge pll_clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge pll_clk);
            for (int c = 0; c < 3; c++) if (led_o[c] == 1'b0) lows[c]++;
        end
        check_val({tag, "_ch0"}, lows[0], e0);
        check_val({tag, "_ch1"}, lows[1], e1);
        check_val({tag, "_ch2"}, lows[2], e2);
    endtask

    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge pll_clk);
            if (uart_tx_o == 1'b0) begin
                repeat (CPB / 2) @(negedge pll_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge pll_clk);
                    b[i] = uart_tx_o;
                end
                repeat (CPB) @(negedge pll_clk);
                if (uart_tx_o !== 1'b1) tx_stop_bad++;
                tx_q.push_back(b);
                $display("tx reply 0x%02h", b);
            end
        end
    end

    initial begin
        int bad;
        rst_n     = 1'b0;
        uart_rx_i = 1'b1;
        repeat (5) @(negedge pll_clk);
        check_val("reset_tx", int'(uart_tx_o), 1);
        check_val("reset_led", int'(led_o), 3'b111);
        rst_n = 1'b1;

        // 1: idle outputs hold after release
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge pll_clk);
            if (led_o !== 3'b111 || uart_tx_o !== 1'b1) bad++;
        end
        check_val("idle_hold_bad_cycles", bad, 0);

        // 2: write channel 1 to 64
        send_byte(8'h81, 1'b1);
        send_byte(8'h40, 1'b1);
        expect_reply("ack_81", 8'h81);
        measure("duty_t2", 0, 64, 0);

        // 3: out-of-range channel gets NAK and changes nothing
        send_byte(8'h85, 1'b1);
        send_byte(8'h10, 1'b1);
        expect_reply("nak_85", 8'h15);
        measure("duty_t3", 0, 64, 0);

        // 4: header timeout; the late 0xFF becomes a header itself, so let it time out too
        send_byte(8'h80, 1'b1);
        repeat (40 * CPB) @(negedge pll_clk);
        send_byte(8'hFF, 1'b1);
        repeat (40 * CPB) @(negedge pll_clk);
        check_val("timeout_no_reply", tx_q.size(), 0);
        measure("duty_t4a", 0, 64, 0);
        send_byte(8'h80, 1'b1);
        send_byte(8'hFF, 1'b1);
        expect_reply("ack_80_ff", 8'h80);
        measure("duty_t4b", 255, 64, 0);

        // 5: framing error on a would-be header, then a short line glitch
        send_byte(8'h83, 1'b0);
        repeat (50) @(negedge pll_clk);
        uart_rx_i = 1'b0;
        repeat (3) @(negedge pll_clk);
        uart_rx_i = 1'b1;
        repeat (200) @(negedge pll_clk);
        check_val("frame_glitch_no_reply", tx_q.size(), 0);
        send_byte(8'h82, 1'b1);
        send_byte(8'h00, 1'b1);
        expect_reply("ack_82", 8'h82);
        measure("duty_t5", 255, 64, 0);

        // 6: reset in the middle of a duty byte
        send_byte(8'h81, 1'b1);
        @(negedge pll_clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge pll_clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx_i = i[0];
            repeat (CPB) @(negedge pll_clk);
        end
        rst_n = 1'b0;
        #1;
        check_val("midreset_tx", int'(uart_tx_o), 1);
        check_val("midreset_led", int'(led_o), 3'b111);
        uart_rx_i = 1'b1;
        repeat (20) @(negedge pll_clk);
        rst_n = 1'b1;
        repeat (20) @(negedge pll_clk);
        send_byte(8'h80, 1'b1);
        send_byte(8'h80, 1'b1);
        expect_reply("ack_80_half", 8'h80);
        measure("duty_t6", 128, 0, 0);
        check_val("tx_leftover_replies", tx_q.size(), 0);
        check_val("tx_stop_bits_bad", tx_stop_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
